ibert_seq_router: RTL and testbench
===================================

Name: ibert_seq_router

Overview:
- Top-level stream sequencer for the encoder pipeline; successor to the fixed four-stage IBERT wrapper.
- Routes the single host input stream in a fixed order: input activations first, then weight packets to a parametrised number of weight consumers (head, self-out, inter, layer-out).
- Recirculates layer-out results as the next layer's activations.
- Exposes only the final layer's result on y, plus an optional per-layer debug mode.
- Layer count is runtime-programmable. A completed inference returns the block to input loading.

Parameters:
- DATA_W, 32, stream data width.
- N_W, 4, number of weight consumers: 0=head, 1=self, 2=inter, 3=layer.
- HEADS, 12, head weight packets per layer.
- SLICES, 8, token slices per layer. Each slice carries one weight packet for each of consumers 1..N_W-1.
- ACT_WORDS, 24576, input activation words (TOKENS*EMBED_SIZE).
- CNT_W, 24, width of the activation word counter.
- LAYER_W, 4, width of cfg_layers and layer_idx.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_layers  in  LAYER_W  number of layers per inference (0 treated as 1); sampled on entry to ACT
- cfg_dbg  in  1  1 = y also carries intermediate-layer results
- x_tdata/x_tvalid/x_tlast  in  DATA_W/1/1  host stream
- x_tready  out  1  host backpressure
- w_tdata  out  DATA_W  shared weight data (= x_tdata)
- w_tvalid/w_tlast  out  N_W/N_W  one-hot per consumer
- w_tready/w_rcvd  in  N_W/N_W  consumer ready; one-cycle pulse when a consumer's full packet is received
- a_tdata/a_tvalid/a_tlast  out  DATA_W/1/1  activation stream to the head and self residual sinks
- a_tready  in  1  AND of the sinks' readies
- l_tdata/l_tvalid/l_tlast  in  DATA_W/1/1  layer-out result stream
- l_tready  out  1
- y_tdata/y_tvalid/y_tlast  out  DATA_W/1/1  result stream
- y_tready  in  1
- layer_idx  out  LAYER_W  current layer being loaded
- done  out  1  one-cycle pulse on the final y beat of an inference

Behaviour:
- Reset values: x_tready, w_tvalid, w_tlast, a_tvalid, a_tlast, l_tready, y_tvalid, y_tlast, done all 0; layer_idx 0; all counters 0; in_fsm=ACT; out_fsm=WAIT.
- Input FSM states: ACT, HEAD, SLICE_W(k) for k=1..N_W-1.
  - ACT: a_* = x_*; x_tready = a_tready. An act_cnt beat counter wraps at ACT_WORDS-1. a_tlast is asserted on that beat (host x_tlast is ignored). Leaving ACT latches nl = max(cfg_layers,1) and moves to HEAD.
  - HEAD: w_tvalid[0] = x_tvalid; x_tready = w_tready[0]. Each w_rcvd[0] increments head_cnt. At HEADS-1, head_cnt clears and the FSM moves to SLICE_W(1).
  - SLICE_W(k): routes to consumer k; w_rcvd[k] advances to k+1. After N_W-1, slice_cnt increments. At SLICES-1: if layer_idx == nl-1, go to ACT and clear layer_idx; else increment layer_idx and go to HEAD.
  - w_rcvd on a non-selected consumer is ignored.
- Output FSM states: WAIT, STREAM. It tracks the layer-out packet count (SLICES packets per layer) and its own out_layer counter.
  - Non-final layer: l_* drives a_* (recirculation). Non-final layer and cfg_dbg=1: also copied to y. l_tready = a_tready & (y_tready | !cfg_dbg).
  - Final layer: l_* drives y only; l_tready = y_tready. y_tlast is asserted only on l_tlast of slice SLICES-1. done pulses with that beat.
  - a_tlast during recirculation = l_tlast on slice SLICES-1.
- Arbitration of a_*: in_fsm=ACT owns it; otherwise recirculation owns it. Both active at once never occurs by construction; the bench asserts this.
- All routing is combinational (zero latency); only counters and FSM states are registered.
- Simultaneous w_rcvd and state change: the count is applied, then the transition is taken in the same edge.
- rst_n mid-packet: everything returns to reset values next edge; partially transferred packets are abandoned.
- cfg_layers changes mid-inference take effect only at the next ACT exit.

Decomposition:
- Package ibert_seq_pkg holds:
  - the input-state enum and output-state enum;
  - consumer index constants W_HEAD=0, W_SELF=1, W_INTER=2, W_LAYER=3;
  - a function clog2-safe widths helper.
- One sub-module, ibert_seq_cnt: a wrap counter with params MAX and W, inputs inc and clr, outputs value and last.

Test Plan:
- 1 layer, HEADS=2, SLICES=2, N_W=4, ACT_WORDS=8:
  - 8 x beats → a_tlast on beat 8 only.
  - 2 head packets → state SLICE_W(1).
  - 6 slice packets → in_fsm returns to ACT and layer_idx=0.
- cfg_layers=3, cfg_dbg=0: 3×SLICES layer-out packets → first 2 layers appear only on a_*, y silent; third layer appears on y with one y_tlast and one done pulse.
- Same configuration with cfg_dbg=1 and y_tready low: l_tready held 0 and no a_* beat is lost; releasing y_tready resumes the stream.
- Backpressure: randomly toggle w_tready[2] during SLICE_W(2) → x_tready mirrors it; no beat reaches consumers 0, 1 or 3.
- Spurious w_rcvd[3] pulse during HEAD → ignored; head_cnt unchanged.
- rst_n asserted mid-ACT at beat 5 → next cycle all outputs 0; the following run restarts act_cnt at 0.

Source files
------------

// File: rtl/ibert_seq_router_pkg.sv
// Shared types and helpers for the IBERT stream sequencer: FSM state
// encodings, weight-consumer indices and a width helper.
package ibert_seq_pkg;

    typedef enum logic [1:0] {
        IN_ACT   = 2'd0,
        IN_HEAD  = 2'd1,
        IN_SLICE = 2'd2
    } in_state_e;

    typedef enum logic {
        OUT_WAIT   = 1'b0,
        OUT_STREAM = 1'b1
    } out_state_e;

    localparam int W_HEAD  = 0;
    localparam int W_SELF  = 1;
    localparam int W_INTER = 2;
    localparam int W_LAYER = 3;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int safe_clog2(input int n);
        int r;
        if (n <= 1) begin
            r = 1;
        end else begin
            r = $clog2(n);
        end
        return r;
    endfunction

endpackage

// File: rtl/ibert_seq_router_if.sv
// Bundles the host, weight, activation, layer-out and result streams of the
// sequencer. slave is the router's view, master the surrounding pipeline's.
interface ibert_seq_router_if #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4
) ();
    logic [DATA_W-1:0] x_tdata;
    logic              x_tvalid;
    logic              x_tlast;
    logic              x_tready;
    logic [DATA_W-1:0] w_tdata;
    logic [N_W-1:0]    w_tvalid;
    logic [N_W-1:0]    w_tlast;
    logic [N_W-1:0]    w_tready;
    logic [N_W-1:0]    w_rcvd;
    logic [DATA_W-1:0] a_tdata;
    logic              a_tvalid;
    logic              a_tlast;
    logic              a_tready;
    logic [DATA_W-1:0] l_tdata;
    logic              l_tvalid;
    logic              l_tlast;
    logic              l_tready;
    logic [DATA_W-1:0] y_tdata;
    logic              y_tvalid;
    logic              y_tlast;
    logic              y_tready;

    modport slave (
        input  x_tdata, x_tvalid, x_tlast,
        output x_tready,
        output w_tdata, w_tvalid, w_tlast,
        input  w_tready, w_rcvd,
        output a_tdata, a_tvalid, a_tlast,
        input  a_tready,
        input  l_tdata, l_tvalid, l_tlast,
        output l_tready,
        output y_tdata, y_tvalid, y_tlast,
        input  y_tready
    );

    modport master (
        output x_tdata, x_tvalid, x_tlast,
        input  x_tready,
        input  w_tdata, w_tvalid, w_tlast,
        output w_tready, w_rcvd,
        input  a_tdata, a_tvalid, a_tlast,
        output a_tready,
        output l_tdata, l_tvalid, l_tlast,
        input  l_tready,
        input  y_tdata, y_tvalid, y_tlast,
        output y_tready
    );
endinterface

// File: rtl/ibert_seq_router_cnt.sv
// Wrap counter: counts inc pulses 0..MAX and wraps to 0; last flags MAX.
module ibert_seq_cnt #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         last
);
    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1'b1);
    localparam logic [W-1:0] ZERO_V = {W{1'b0}};

    logic [W-1:0] value_r;

    assign value = value_r;
    assign last  = (value_r == MAX_V);

    // Count register with clear priority over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_r <= ZERO_V;
        end else if (clr) begin
            value_r <= ZERO_V;
        end else if (inc) begin
            if (last) begin
                value_r <= ZERO_V;
            end else begin
                value_r <= value_r + ONE_V;
            end
        end else begin
            value_r <= value_r;
        end
    end
endmodule

// File: rtl/ibert_seq_router.sv
// Encoder stream sequencer: routes host activations then per-layer weights,
// recirculates layer-out results and exposes the final layer on y.
module ibert_seq_router
    import ibert_seq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int N_W       = 4,
    parameter int HEADS     = 12,
    parameter int SLICES    = 8,
    parameter int ACT_WORDS = 24576,
    parameter int CNT_W     = 24,
    parameter int LAYER_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LAYER_W-1:0] cfg_layers,
    input  logic               cfg_dbg,
    ibert_seq_router_if.slave  bus,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               done
);
    localparam int HEAD_W = safe_clog2(HEADS);
    localparam int SLC_W  = safe_clog2(SLICES);
    localparam int SEL_W  = safe_clog2(N_W);
    localparam logic [LAYER_W-1:0] ONE_L    = LAYER_W'(1'b1);
    localparam logic [LAYER_W-1:0] ZERO_L   = {LAYER_W{1'b0}};
    localparam logic [SEL_W-1:0]   SEL_ONE  = SEL_W'(1'b1);
    localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(N_W - 1);

    in_state_e          in_state_r, in_next_s;
    out_state_e         out_state_r, out_next_s;
    logic [SEL_W-1:0]   w_sel_r, sel_next_s;
    logic [LAYER_W-1:0] layer_idx_r, layer_next_s;
    logic [LAYER_W-1:0] nl_r, nl_next_s;
    logic [LAYER_W-1:0] out_layer_r, out_layer_next_s;

    logic [CNT_W-1:0]  act_cnt_s;
    logic [HEAD_W-1:0] head_cnt_s;
    logic [SLC_W-1:0]  slice_cnt_s;
    logic [SLC_W-1:0]  pkt_cnt_s;
    logic act_last_s, head_last_s, slice_last_s, pkt_last_s;
    logic act_inc_s, head_inc_s, slice_inc_s, pkt_inc_s;
    logic cnt_unused_s;

    logic              x_ready_s, act_a_valid_s, act_a_last_s;
    logic [N_W-1:0]    w_valid_s, w_last_s;
    logic              final_s, l_ready_s, l_beat_s, rc_valid_s, rc_last_s;
    logic              y_valid_s, y_last_s, done_s;
    logic [DATA_W-1:0] a_data_s;
    logic              a_valid_s, a_last_s;

    ibert_seq_cnt #(.MAX(ACT_WORDS - 1), .W(CNT_W)) u_act_cnt (
        .clk(clk), .rst_n(rst_n), .inc(act_inc_s), .clr(1'b0),
        .value(act_cnt_s), .last(act_last_s));
    ibert_seq_cnt #(.MAX(HEADS - 1), .W(HEAD_W)) u_head_cnt (
        .clk(clk), .rst_n(rst_n), .inc(head_inc_s), .clr(1'b0),
        .value(head_cnt_s), .last(head_last_s));
    ibert_seq_cnt #(.MAX(SLICES - 1), .W(SLC_W)) u_slice_cnt (
        .clk(clk), .rst_n(rst_n), .inc(slice_inc_s), .clr(1'b0),
        .value(slice_cnt_s), .last(slice_last_s));
    ibert_seq_cnt #(.MAX(SLICES - 1), .W(SLC_W)) u_pkt_cnt (
        .clk(clk), .rst_n(rst_n), .inc(pkt_inc_s), .clr(1'b0),
        .value(pkt_cnt_s), .last(pkt_last_s));

    assign cnt_unused_s = ^{act_cnt_s, head_cnt_s, slice_cnt_s, pkt_cnt_s};

    // Input sequencing: ACT -> HEAD -> SLICE(1..N_W-1) per slice, per layer.
    always_comb begin
        in_next_s     = in_state_r;
        sel_next_s    = w_sel_r;
        layer_next_s  = layer_idx_r;
        nl_next_s     = nl_r;
        act_inc_s     = 1'b0;
        head_inc_s    = 1'b0;
        slice_inc_s   = 1'b0;
        x_ready_s     = 1'b0;
        act_a_valid_s = 1'b0;
        act_a_last_s  = 1'b0;
        w_valid_s     = {N_W{1'b0}};
        w_last_s      = {N_W{1'b0}};
        case (in_state_r)
            IN_ACT: begin
                x_ready_s     = bus.a_tready;
                act_a_valid_s = bus.x_tvalid;
                act_a_last_s  = act_last_s;
                if (bus.x_tvalid && bus.a_tready) begin
                    act_inc_s = 1'b1;
                    if (act_last_s) begin
                        in_next_s = IN_HEAD;
                        nl_next_s = (cfg_layers == ZERO_L) ? ONE_L : cfg_layers;
                    end else begin
                        in_next_s = IN_ACT;
                    end
                end else begin
                    in_next_s = IN_ACT;
                end
            end
            IN_HEAD: begin
                x_ready_s        = bus.w_tready[W_HEAD];
                w_valid_s[W_HEAD] = bus.x_tvalid;
                w_last_s[W_HEAD]  = bus.x_tlast;
                if (bus.w_rcvd[W_HEAD]) begin
                    head_inc_s = 1'b1;
                    if (head_last_s) begin
                        in_next_s  = IN_SLICE;
                        sel_next_s = SEL_W'(W_SELF);
                    end else begin
                        in_next_s = IN_HEAD;
                    end
                end else begin
                    in_next_s = IN_HEAD;
                end
            end
            IN_SLICE: begin
                x_ready_s          = bus.w_tready[w_sel_r];
                w_valid_s[w_sel_r] = bus.x_tvalid;
                w_last_s[w_sel_r]  = bus.x_tlast;
                if (bus.w_rcvd[w_sel_r]) begin
                    if (w_sel_r == SEL_LAST) begin
                        slice_inc_s = 1'b1;
                        sel_next_s  = SEL_W'(W_SELF);
                        if (!slice_last_s) begin
                            in_next_s = IN_SLICE;
                        end else if (layer_idx_r == nl_r - ONE_L) begin
                            in_next_s    = IN_ACT;
                            layer_next_s = ZERO_L;
                        end else begin
                            in_next_s    = IN_HEAD;
                            layer_next_s = layer_idx_r + ONE_L;
                        end
                    end else begin
                        sel_next_s = w_sel_r + SEL_ONE;
                    end
                end else begin
                    in_next_s = IN_SLICE;
                end
            end
            default: begin
                in_next_s = IN_ACT;
            end
        endcase
    end

    // Input FSM state, consumer select and layer bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_state_r  <= IN_ACT;
            w_sel_r     <= {SEL_W{1'b0}};
            layer_idx_r <= ZERO_L;
            nl_r        <= ONE_L;
        end else begin
            in_state_r  <= in_next_s;
            w_sel_r     <= sel_next_s;
            layer_idx_r <= layer_next_s;
            nl_r        <= nl_next_s;
        end
    end

    assign final_s = (out_layer_r == nl_r - ONE_L);

    // Layer-out routing; recirculation only once ACT has released a_*.
    always_comb begin
        l_ready_s        = 1'b0;
        rc_valid_s       = 1'b0;
        rc_last_s        = 1'b0;
        y_valid_s        = 1'b0;
        y_last_s         = 1'b0;
        done_s           = 1'b0;
        pkt_inc_s        = 1'b0;
        out_next_s       = out_state_r;
        out_layer_next_s = out_layer_r;
        if (final_s) begin
            y_valid_s = bus.l_tvalid;
            y_last_s  = bus.l_tlast & pkt_last_s;
            l_ready_s = bus.y_tready;
        end else if (in_state_r != IN_ACT) begin
            // a_tvalid is held off while y stalls in debug so no beat is duplicated.
            rc_valid_s = bus.l_tvalid & (bus.y_tready | ~cfg_dbg);
            rc_last_s  = bus.l_tlast & pkt_last_s;
            y_valid_s  = cfg_dbg & bus.l_tvalid & bus.a_tready;
            l_ready_s  = bus.a_tready & (bus.y_tready | ~cfg_dbg);
        end else begin
            l_ready_s = 1'b0;
        end
        l_beat_s = rst_n & l_ready_s & bus.l_tvalid;
        case (out_state_r)
            OUT_WAIT: begin
                if (l_beat_s && !bus.l_tlast) begin
                    out_next_s = OUT_STREAM;
                end else begin
                    out_next_s = OUT_WAIT;
                end
            end
            OUT_STREAM: begin
                if (l_beat_s && bus.l_tlast) begin
                    out_next_s = OUT_WAIT;
                end else begin
                    out_next_s = OUT_STREAM;
                end
            end
            default: begin
                out_next_s = OUT_WAIT;
            end
        endcase
        if (l_beat_s && bus.l_tlast) begin
            pkt_inc_s = 1'b1;
            if (pkt_last_s) begin
                done_s           = final_s;
                out_layer_next_s = final_s ? ZERO_L : (out_layer_r + ONE_L);
            end else begin
                out_layer_next_s = out_layer_r;
            end
        end else begin
            pkt_inc_s = 1'b0;
        end
    end

    // Output FSM state and result-layer counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_state_r <= OUT_WAIT;
            out_layer_r <= ZERO_L;
        end else begin
            out_state_r <= out_next_s;
            out_layer_r <= out_layer_next_s;
        end
    end

    // a_* ownership: ACT loading first, recirculation otherwise.
    always_comb begin
        a_data_s  = bus.x_tdata;
        a_valid_s = 1'b0;
        a_last_s  = 1'b0;
        if (in_state_r == IN_ACT) begin
            a_data_s  = bus.x_tdata;
            a_valid_s = act_a_valid_s;
            a_last_s  = act_a_last_s;
        end else begin
            a_data_s  = bus.l_tdata;
            a_valid_s = rc_valid_s;
            a_last_s  = rc_last_s;
        end
    end

    assign bus.x_tready = rst_n & x_ready_s;
    assign bus.w_tdata  = bus.x_tdata;
    assign bus.w_tvalid = w_valid_s & {N_W{rst_n}};
    assign bus.w_tlast  = w_last_s & {N_W{rst_n}};
    assign bus.a_tdata  = a_data_s;
    assign bus.a_tvalid = rst_n & a_valid_s;
    assign bus.a_tlast  = rst_n & a_last_s;
    assign bus.l_tready = rst_n & l_ready_s;
    assign bus.y_tdata  = bus.l_tdata;
    assign bus.y_tvalid = rst_n & y_valid_s;
    assign bus.y_tlast  = rst_n & y_last_s;
    assign layer_idx    = layer_idx_r;
    assign done         = done_s;

endmodule

// File: tb/tb_ibert_seq_router.sv
// Directed bench for ibert_seq_router with a small configuration
// (HEADS=2, SLICES=2, N_W=4, ACT_WORDS=8).
module tb_ibert_seq_router;
    import ibert_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] cfg_layers;
    logic       cfg_dbg;
    logic [3:0] layer_idx;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ylast_cnt = 0;
    int a_cnt = 0;
    int arb_err = 0;

    ibert_seq_router_if #(.DATA_W(32), .N_W(4)) bus ();

    ibert_seq_router #(
        .DATA_W(32), .N_W(4), .HEADS(2), .SLICES(2),
        .ACT_WORDS(8), .CNT_W(4), .LAYER_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_layers(cfg_layers), .cfg_dbg(cfg_dbg),
        .bus(bus), .layer_idx(layer_idx), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled at the active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (done) done_cnt <= done_cnt + 1;
            if (bus.y_tvalid && bus.y_tready && bus.y_tlast) ylast_cnt <= ylast_cnt + 1;
            if (bus.a_tvalid && bus.a_tready) a_cnt <= a_cnt + 1;
        end
    end

    // ACT and recirculation must never drive a_* together.
    always @(negedge clk) begin
        if (rst_n && dut.in_state_r == IN_ACT && dut.rc_valid_s) arb_err <= arb_err + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timed out");
    end

    typedef struct {
        logic        xv;
        logic        ar;
        logic [3:0]  wr;
        logic [3:0]  wc;
        logic [14:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [14:0] ob(logic xr, logic av, logic al, logic [3:0] wv,
                                       logic lr, logic yv, logic yl, logic dn, logic [3:0] li);
        return {xr, av, al, wv, lr, yv, yl, dn, li};
    endfunction

    function automatic vec_t mk(logic xv, logic ar, logic [3:0] wr, logic [3:0] wc, logic [14:0] e);
        vec_t v;
        v.xv = xv; v.ar = ar; v.wr = wr; v.wc = wc; v.exp = e;
        return v;
    endfunction

    function automatic logic [14:0] outs();
        return {bus.x_tready, bus.a_tvalid, bus.a_tlast, bus.w_tvalid, bus.l_tready,
                bus.y_tvalid, bus.y_tlast, done, layer_idx};
    endfunction

    task automatic check(input string nm, input int idx, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic act_beats(input int n);
        for (int i = 0; i < n; i++) begin
            bus.x_tvalid = 1'b1;
            bus.x_tdata  = 32'(i);
            bus.a_tready = 1'b1;
            step();
        end
        bus.x_tvalid = 1'b0;
    endtask

    task automatic rcvd(input int k);
        bus.w_rcvd = 4'b0001 << k;
        step();
        bus.w_rcvd = 4'b0000;
    endtask

    task automatic l_beat(input int layer, input int pkt, input int beat, input logic dbg);
        logic fin, lst, tl;
        logic [31:0] d;
        logic [37:0] got, want;
        fin = (layer == 2);
        lst = (beat == 1);
        tl  = lst && (pkt == 1);
        d   = 32'hA500_0000 + 32'(layer * 256 + pkt * 16 + beat);
        bus.l_tdata  = d;
        bus.l_tvalid = 1'b1;
        bus.l_tlast  = lst;
        #1;
        if (fin) want = {1'b0, 1'b0, 1'b1, tl, tl, 1'b1, d};
        else     want = {1'b1, tl, dbg, 1'b0, 1'b0, 1'b1, d};
        got = {bus.a_tvalid, bus.a_tlast, bus.y_tvalid, bus.y_tlast, done, bus.l_tready,
               fin ? bus.y_tdata : bus.a_tdata};
        check("l_beat", layer * 4 + pkt * 2 + beat, 64'(got), 64'(want));
        @(posedge clk);
        #1;
        bus.l_tvalid = 1'b0;
        bus.l_tlast  = 1'b0;
    endtask

    task automatic run_layers(input logic dbg);
        for (int l = 0; l < 3; l++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 2; b++)
                    l_beat(l, p, b, dbg);
    endtask

    initial begin
        logic [3:0] hw [4];
        logic [3:0] oh;
        int d0, y0, a0;

        rst_n = 1'b0; cfg_layers = 4'd1; cfg_dbg = 1'b0;
        bus.x_tdata = 32'd0; bus.x_tvalid = 1'b1; bus.x_tlast = 1'b0;
        bus.w_tready = 4'b1111; bus.w_rcvd = 4'b0000; bus.a_tready = 1'b1;
        bus.l_tdata = 32'd0; bus.l_tvalid = 1'b1; bus.l_tlast = 1'b1; bus.y_tready = 1'b1;
        step();
        step();
        check("reset_outs", 0, 64'({outs(), bus.w_tlast}), 64'd0);
        bus.x_tvalid = 1'b0; bus.l_tvalid = 1'b0; bus.l_tlast = 1'b0; bus.w_tready = 4'b0000;
        rst_n = 1'b1;

        // Single-layer load: 8 activations, 2 heads (one spurious rcvd[3]), 2x3 slices.
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(1'b1, 1'b1, 4'b0000, 4'b0000,
                            ob(1'b1, 1'b1, (i == 7), 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0)));
        hw = '{4'b0000, 4'b0001, 4'b1000, 4'b0001};
        for (int j = 0; j < 4; j++)
            vq.push_back(mk(1'b1, 1'b1, 4'b0001, hw[j],
                            ob(1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0)));
        for (int s = 0; s < 2; s++)
            for (int k = 1; k < 4; k++) begin
                oh = 4'b0001 << k;
                vq.push_back(mk(1'b1, 1'b1, oh, oh,
                                ob(1'b1, 1'b0, 1'b0, oh, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0)));
            end
        vq.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000,
                        ob(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0)));

        for (int i = 0; i < vq.size(); i++) begin
            bus.x_tvalid = vq[i].xv;
            bus.x_tdata  = 32'(i);
            bus.a_tready = vq[i].ar;
            bus.w_tready = vq[i].wr;
            bus.w_rcvd   = vq[i].wc;
            #1;
            check("vec", i, 64'(outs()), 64'(vq[i].exp));
            step();
        end
        bus.x_tvalid = 1'b0; bus.w_rcvd = 4'b0000; bus.w_tready = 4'b0000;

        // Three layers, no debug: only the last layer reaches y.
        do_reset();
        cfg_layers = 4'd3; cfg_dbg = 1'b0;
        act_beats(8);
        d0 = done_cnt; y0 = ylast_cnt;
        run_layers(1'b0);
        check("done_pulses", 0, 64'(done_cnt - d0), 64'd1);
        check("ylast_beats", 0, 64'(ylast_cnt - y0), 64'd1);

        // Debug mode with y stalled: layer-out must hold, nothing leaks onto a_*.
        cfg_dbg = 1'b1;
        a0 = a_cnt; d0 = done_cnt;
        bus.y_tready = 1'b0; bus.l_tvalid = 1'b1; bus.l_tdata = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("dbg_stall", i, 64'({bus.l_tready, bus.a_tvalid, bus.y_tvalid}), 64'(3'b001));
            step();
        end
        bus.y_tready = 1'b1;
        run_layers(1'b1);
        check("dbg_a_beats", 0, 64'(a_cnt - a0), 64'd8);
        check("dbg_done", 0, 64'(done_cnt - d0), 64'd1);

        // Two layers of weights, then backpressure on consumer 2.
        do_reset();
        cfg_layers = 4'd2; cfg_dbg = 1'b0;
        act_beats(8);
        rcvd(0); rcvd(0);
        for (int s = 0; s < 2; s++) begin rcvd(1); rcvd(2); rcvd(3); end
        bus.x_tvalid = 1'b1; bus.w_tready = 4'b0001;
        #1;
        check("layer1_head", 0, 64'({bus.x_tready, bus.w_tvalid, layer_idx}), 64'({1'b1, 4'b0001, 4'd1}));
        step();
        rcvd(0); rcvd(0); rcvd(1);
        for (int i = 0; i < 8; i++) begin
            bus.w_tready = 4'($urandom_range(0, 15));
            #1;
            check("bp_w2", i, 64'({bus.x_tready, bus.w_tvalid}), 64'({bus.w_tready[2], 4'b0100}));
            step();
        end
        bus.x_tvalid = 1'b0; bus.w_tready = 4'b0000;

        // Reset in the middle of activation loading, then reload from zero.
        do_reset();
        cfg_layers = 4'd1;
        act_beats(5);
        bus.x_tvalid = 1'b1; bus.a_tready = 1'b1; bus.y_tready = 1'b1; bus.w_tready = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("mid_rst", 0, 64'({outs(), bus.w_tlast}), 64'd0);
        step();
        check("mid_rst", 1, 64'({outs(), bus.w_tlast}), 64'd0);
        rst_n = 1'b1; bus.w_tready = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            bus.x_tvalid = 1'b1;
            #1;
            check("restart_act", i, 64'({bus.a_tvalid, bus.a_tlast}), 64'({1'b1, (i == 7)}));
            step();
        end
        bus.x_tvalid = 1'b0;
        step();
        check("arb_overlap", 0, 64'(arb_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
